// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin arbiter sharing one bit-serial adder among NREQ requesters,
// returning id-tagged sums (or a timeout error) over a single valid/ready response channel.
module serial_add_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 31,
   parameter int CW      = 5,
   parameter int IDW     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_err,
   output logic                  add_start,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   input  logic                  add_done,
   input  logic [WIDTH-1:0]      add_sum,
   output logic                  busy,
   output logic [7:0]            err_count
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
   state_t state, state_nx;
   logic [IDW-1:0] ptr, grant;
   logic any;
   logic [CW-1:0] timer;
   logic timeout;

   assign timeout = timer == CW'(TIMEOUT);

   // Walk downward so the nearest requester after ptr is the last (winning) assignment.
   always_comb begin
      grant = '0;
      any = 1'b0;
      for (int i = NREQ; i >= 1; i--) begin
         if (req_valid[(int'(ptr) + i) % NREQ]) begin
            grant = IDW'((int'(ptr) + i) % NREQ);
            any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = any ? LOAD : IDLE;
         LOAD: state_nx = RUN;
         RUN:  state_nx = (add_done || timeout) ? RESP : RUN;
         RESP: state_nx = rsp_ready ? IDLE : RESP;
      endcase
   end

   // req_ready is masked during reset so every output reads 0 while rst is high.
   always_comb begin
      req_ready = (state == IDLE && any && !rst) ? NREQ'(1) << grant : '0;
      add_start = state == LOAD;
      rsp_valid = state == RESP;
      busy      = state != IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= IDW'(NREQ - 1);
         add_a     <= '0;
         add_b     <= '0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_err   <= 1'b0;
         err_count <= '0;
         timer     <= '0;
      end else begin
         case (state)
            IDLE: if (any) begin
               add_a  <= req_a[int'(grant)*WIDTH +: WIDTH];
               add_b  <= req_b[int'(grant)*WIDTH +: WIDTH];
               rsp_id <= grant;
            end
            LOAD: timer <= '0;
            RUN: begin
               timer <= timer + 1'b1;
               if (add_done) begin
                  rsp_sum <= add_sum;
                  rsp_err <= 1'b0;
               end else if (timeout) begin
                  rsp_sum   <= '0;
                  rsp_err   <= 1'b1;
                  err_count <= err_count + 8'(err_count != 8'hFF);
               end
            end
            RESP: if (rsp_ready) ptr <= rsp_id;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: directed and randomized checks of serial_add_sched against a
// round-robin/timeout reference model; the adder is modelled as a + b with chosen latency.
module tb_serial_add_sched;
   localparam int NREQ = 4, WIDTH = 8, TIMEOUT = 31;

   logic clk = 1'b0, rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0, req_ready;
   logic [NREQ*WIDTH-1:0] req_a = '0, req_b = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_err, add_start, add_done = 1'b0, busy;
   logic [1:0] rsp_id;
   logic [WIDTH-1:0] rsp_sum, add_a, add_b, add_sum = '0;
   logic [7:0] err_count;

   int vectors = 0, miscompares = 0;
   int ptr_m = NREQ - 1, errc_m = 0;
   logic [7:0] av[NREQ], bv[NREQ];

   serial_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(5), .IDW(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
      .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_err(rsp_err), .add_start(add_start), .add_a(add_a),
      .add_b(add_b), .add_done(add_done), .add_sum(add_sum), .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string ctx);
      chk({ctx, " req_ready"}, 32'(req_ready), 0);
      chk({ctx, " rsp_valid"}, 32'(rsp_valid), 0);
      chk({ctx, " rsp_id"}, 32'(rsp_id), 0);
      chk({ctx, " rsp_sum"}, 32'(rsp_sum), 0);
      chk({ctx, " rsp_err"}, 32'(rsp_err), 0);
      chk({ctx, " add_start"}, 32'(add_start), 0);
      chk({ctx, " add_a"}, 32'(add_a), 0);
      chk({ctx, " add_b"}, 32'(add_b), 0);
      chk({ctx, " busy"}, 32'(busy), 0);
      chk({ctx, " err_count"}, 32'(err_count), 0);
   endtask

   task automatic pack();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = av[i];
         req_b[i*WIDTH +: WIDTH] = bv[i];
      end
   endtask

   // Round robin: first pending requester after the last one served.
   function automatic int pick();
      for (int i = 1; i <= NREQ; i++)
         if (req_valid[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
      return 0;
   endfunction

   // One full operation from a negedge in IDLE; lat = RUN cycle of add_done (>TIMEOUT: never).
   task automatic do_op(input int lat, input int hold, input bit keep);
      int g;
      logic [7:0] es;
      logic eerr;
      #1;
      g = pick();
      chk("grant", 32'(req_ready), 32'(1) << g);
      @(negedge clk);
      chk("load add_start", 32'(add_start), 1);
      chk("load add_a", 32'(add_a), 32'(av[g]));
      chk("load add_b", 32'(add_b), 32'(bv[g]));
      chk("load busy", 32'(busy), 1);
      chk("load req_ready", 32'(req_ready), 0);
      if (!keep) req_valid[g] = 1'b0;
      add_done = 1'b0;
      es = 8'h00;
      eerr = 1'b1;
      for (int d = 0; d <= TIMEOUT; d++) begin
         @(negedge clk);
         chk("run add_start", 32'(add_start), 0);
         add_done = (d == lat);
         add_sum = av[g] + bv[g];
         if (d == lat) begin
            es = add_sum;
            eerr = 1'b0;
            break;
         end
      end
      if (eerr) errc_m = errc_m < 255 ? errc_m + 1 : 255;
      @(negedge clk);
      add_done = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         chk("rsp_valid", 32'(rsp_valid), 1);
         chk("rsp_id", 32'(rsp_id), 32'(g));
         chk("rsp_sum", 32'(rsp_sum), 32'(es));
         chk("rsp_err", 32'(rsp_err), 32'(eerr));
         chk("err_count", 32'(err_count), 32'(errc_m));
         chk("resp busy", 32'(busy), 1);
         chk("resp req_ready", 32'(req_ready), 0);
         rsp_ready = (h == hold);
         add_done = (h == 0 && hold > 0);
         add_sum = ~es;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      add_done = 1'b0;
      ptr_m = g;
      chk("idle rsp_valid", 32'(rsp_valid), 0);
      chk("idle busy", 32'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
      end
      pack();
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      // basic single request
      av[0] = 8'h3C;
      bv[0] = 8'h05;
      pack();
      req_valid = 4'b0001;
      do_op(9, 0, 0);
      // all requesters held: rotating grants
      req_valid = 4'b1111;
      repeat (5) do_op(9, 0, 1);
      req_valid = 4'b0000;
      // adder never finishes
      req_valid = 4'b0100;
      do_op(100, 0, 0);
      // stalled response with others pending, then resume
      req_valid = 4'b1011;
      do_op(4, 5, 0);
      do_op(3, 0, 0);
      do_op(0, 0, 0);
      // done coincident with final timer value
      req_valid = 4'b0010;
      do_op(TIMEOUT, 0, 0);
      // async reset mid-RUN
      req_valid = 4'b0110;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("async rst");
      av[0] = 8'h11;
      bv[0] = 8'h22;
      pack();
      req_valid = 4'b0101;
      @(negedge clk);
      chk_zero("held rst");
      rst = 1'b0;
      ptr_m = NREQ - 1;
      errc_m = 0;
      do_op(5, 0, 0);
      do_op(5, 1, 0);
      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         logic [NREQ-1:0] m;
         m = NREQ'($urandom);
         if ((req_valid | m) == '0) m = 4'b0001;
         for (int i = 0; i < NREQ; i++)
            if (m[i] && !req_valid[i]) begin
               av[i] = 8'($urandom);
               bv[i] = 8'($urandom);
            end
         pack();
         req_valid = req_valid | m;
         do_op(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
